// File: rtl/rgb2yuv_skin_pipe.sv
// RGB -> BT.601 Y/U/V converter with runtime U/V skin-window flag; optional per-frame skin counter (SKIN_COUNT_EN).
// Latency 5 cycles from input acceptance to out_valid, 1 pixel/clock; a single enable stalls every stage under backpressure.
module rgb2yuv_skin_pipe #(
    parameter int IN_W   = 8,
    parameter int COEF_W = 18,
    parameter int CNT_W  = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_red,
    input  logic [IN_W-1:0]  in_grn,
    input  logic [IN_W-1:0]  in_blu,
    input  logic             in_last,
    input  logic [7:0]       u_min,
    input  logic [7:0]       u_max,
    input  logic [7:0]       v_min,
    input  logic [7:0]       v_max,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       o_y,
    output logic [7:0]       o_u,
    output logic [7:0]       o_v,
    output logic             o_skin,
    output logic             o_last,
    output logic [CNT_W-1:0] skin_cnt,
    output logic             skin_cnt_vld
);
    localparam int PW = COEF_W + IN_W + 1;
    localparam int SW = PW + 2;
    // Row order Y, U, V; column order red, green, blue.
    localparam logic signed [COEF_W-1:0] COEF [9] = '{
        COEF_W'(66),  COEF_W'(129), COEF_W'(25),
        COEF_W'(-38), COEF_W'(-74), COEF_W'(112),
        COEF_W'(112), COEF_W'(-94), COEF_W'(-18)};
    localparam logic signed [SW-1:0] RND   = SW'(2**(IN_W-1));
    localparam logic signed [SW-1:0] OFF_Y = SW'(16);
    localparam logic signed [SW-1:0] OFF_C = SW'(128);
    localparam logic signed [SW-1:0] MAX8  = SW'(255);

    function automatic logic signed [PW-1:0] mul(input logic signed [COEF_W-1:0] c,
                                                 input logic [IN_W-1:0] x);
        logic signed [PW-1:0] ce, xe;
        ce = {{(PW-COEF_W){c[COEF_W-1]}}, c};
        xe = {{(PW-IN_W){1'b0}}, x};
        return ce * xe;
    endfunction

    function automatic logic signed [SW-1:0] sx(input logic signed [PW-1:0] p);
        return {{2{p[PW-1]}}, p};
    endfunction

    function automatic logic [7:0] clamp8(input logic signed [SW-1:0] s,
                                          input logic signed [SW-1:0] off);
        logic signed [SW-1:0] t;
        t = (s >>> IN_W) + off;
        if (t[SW-1])       return 8'd0;
        else if (t > MAX8) return 8'd255;
        else               return t[7:0];
    endfunction

    logic                 en;
    logic                 s1_vld, s2_vld, s3_vld, s4_vld, s5_vld;
    logic                 s1_last, s2_last, s3_last, s4_last, s5_last, s5_skin;
    logic [IN_W-1:0]      s1_rgb [3];
    logic signed [PW-1:0] s2_prod [9];
    logic signed [SW-1:0] s3_sum [3];
    logic [7:0]           s4_yuv [3];
    logic [7:0]           s5_y, s5_u, s5_v;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s1_vld, s2_vld, s3_vld, s4_vld, s5_vld, out_valid} <= '0;
            {s1_last, s2_last, s3_last, s4_last, s5_last, o_last} <= '0;
            for (int i = 0; i < 3; i++) begin
                s1_rgb[i] <= '0;
                s3_sum[i] <= '0;
                s4_yuv[i] <= '0;
            end
            for (int i = 0; i < 9; i++) s2_prod[i] <= '0;
            {s5_y, s5_u, s5_v, s5_skin} <= '0;
            {o_y, o_u, o_v, o_skin}     <= '0;
        end else if (en) begin
            s1_vld    <= in_valid;
            s1_last   <= in_last;
            s1_rgb[0] <= in_red;
            s1_rgb[1] <= in_grn;
            s1_rgb[2] <= in_blu;

            s2_vld  <= s1_vld;
            s2_last <= s1_last;
            for (int i = 0; i < 9; i++) s2_prod[i] <= mul(COEF[i], s1_rgb[i % 3]);

            s3_vld  <= s2_vld;
            s3_last <= s2_last;
            for (int k = 0; k < 3; k++)
                s3_sum[k] <= sx(s2_prod[3*k]) + sx(s2_prod[3*k+1]) + sx(s2_prod[3*k+2]) + RND;

            s4_vld    <= s3_vld;
            s4_last   <= s3_last;
            s4_yuv[0] <= clamp8(s3_sum[0], OFF_Y);
            s4_yuv[1] <= clamp8(s3_sum[1], OFF_C);
            s4_yuv[2] <= clamp8(s3_sum[2], OFF_C);

            // Window compare uses the threshold ports as seen right now; an empty window (min>max) never matches.
            s5_vld  <= s4_vld;
            s5_last <= s4_last;
            s5_y    <= s4_yuv[0];
            s5_u    <= s4_yuv[1];
            s5_v    <= s4_yuv[2];
            s5_skin <= (s4_yuv[1] >= u_min) && (s4_yuv[1] <= u_max) &&
                       (s4_yuv[2] >= v_min) && (s4_yuv[2] <= v_max);

            out_valid <= s5_vld;
            o_last    <= s5_last;
            o_y       <= s5_y;
            o_u       <= s5_u;
            o_v       <= s5_v;
            o_skin    <= s5_skin;
        end
    end

`ifdef SKIN_COUNT_EN
    logic             xfer;
    logic [CNT_W-1:0] cnt, cnt_inc;

    assign xfer = out_valid & out_ready;

    always_comb begin
        cnt_inc = cnt;
        if (o_skin && (cnt != {CNT_W{1'b1}})) cnt_inc = cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            skin_cnt     <= '0;
            skin_cnt_vld <= 1'b0;
        end else begin
            skin_cnt_vld <= xfer & o_last;
            if (xfer) begin
                if (o_last) begin
                    skin_cnt <= cnt_inc;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end
`else
    assign skin_cnt     = '0;
    assign skin_cnt_vld = 1'b0;
`endif

endmodule

// File: tb/tb_rgb2yuv_skin_pipe.sv
// Directed bench for rgb2yuv_skin_pipe: expected pixels queued at acceptance, checked as they leave the pipe.
module tb_rgb2yuv_skin_pipe;
    localparam int IN_W  = 8;
    localparam int CNT_W = 20;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
        logic       skin;
        logic       last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_last;
    logic [IN_W-1:0]  in_red, in_grn, in_blu;
    logic [7:0]       u_min, u_max, v_min, v_max;
    logic             out_valid, out_ready;
    logic [7:0]       o_y, o_u, o_v;
    logic             o_skin, o_last;
    logic [CNT_W-1:0] skin_cnt;
    logic             skin_cnt_vld;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   vld_cycles = 0;
    exp_t sb[$];

    rgb2yuv_skin_pipe #(.IN_W(IN_W), .COEF_W(18), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_red(in_red), .in_grn(in_grn), .in_blu(in_blu), .in_last(in_last),
        .u_min(u_min), .u_max(u_max), .v_min(v_min), .v_max(v_max),
        .out_valid(out_valid), .out_ready(out_ready),
        .o_y(o_y), .o_u(o_u), .o_v(o_v), .o_skin(o_skin), .o_last(o_last),
        .skin_cnt(skin_cnt), .skin_cnt_vld(skin_cnt_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cl8(input int x);
        return (x < 0) ? 0 : ((x > 255) ? 255 : x);
    endfunction

    function automatic exp_t model(input int r, input int g, input int b, input logic last);
        exp_t e;
        int   y, u, v;
        y = cl8(((66*r + 129*g + 25*b + 128) >>> 8) + 16);
        u = cl8(((-38*r - 74*g + 112*b + 128) >>> 8) + 128);
        v = cl8(((112*r - 94*g - 18*b + 128) >>> 8) + 128);
        e.y = 8'(y); e.u = 8'(u); e.v = 8'(v);
        e.skin = (u >= int'(u_min)) && (u <= int'(u_max)) && (v >= int'(v_min)) && (v <= int'(v_max));
        e.last = last;
        return e;
    endfunction

    // Scoreboard and handshake monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (skin_cnt_vld) vld_cycles++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_out", out_valid, 1'b0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pixel", {o_y, o_u, o_v, o_skin, o_last}, e);
                    n_out++;
                end
            end
        end
    end

    task automatic send(input int r, input int g, input int b, input logic last, input exp_t e);
        bit ok = 0;
        in_red = 8'(r); in_grn = 8'(g); in_blu = 8'(b); in_last = last;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("in_ready_timeout", in_ready, 1'b1);
        @(posedge clk);
        sb.push_back(e);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_m(input int r, input int g, input int b, input logic last);
        send(r, g, b, last, model(r, g, b, last));
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sb.size() != 0; t++) @(posedge clk);
        chk("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_yuv"}, {o_y, o_u, o_v}, 0);
        chk({tag, "_skin_last"}, {o_skin, o_last}, 0);
        chk({tag, "_skin_cnt"}, {skin_cnt, skin_cnt_vld}, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        rst_n = 1'b0; in_valid = 0; in_last = 0; in_red = 0; in_grn = 0; in_blu = 0;
        out_ready = 1'b1;
        u_min = 8'd73; u_max = 8'd122; v_min = 8'd132; v_max = 8'd173;
        #1 reset_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Black pixel and exact 5-cycle latency.
        in_red = 0; in_grn = 0; in_blu = 0; in_valid = 1'b1;
        @(posedge clk);
        sb.push_back('{y: 8'd16, u: 8'd128, v: 8'd128, skin: 1'b0, last: 1'b0});
        #1 in_valid = 1'b0;
        for (int c = 1; c < 5; c++) begin
            @(posedge clk); #1;
            chk("latency_early", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        chk("latency_5", out_valid, 1'b1);
        drain();

        // White and pure red, checking rounding and clamping.
        send(255, 255, 255, 0, '{y: 8'd235, u: 8'd128, v: 8'd128, skin: 1'b0, last: 1'b0});
        send(255, 0, 0, 0, '{y: 8'd82, u: 8'd90, v: 8'd240, skin: 1'b0, last: 1'b0});
        drain();

        // Skin tone, then window edges.
        send(200, 150, 120, 0, '{y: 8'd155, u: 8'd107, v: 8'd152, skin: 1'b1, last: 1'b0});
        drain();
        v_min = 8'd153;
        send(200, 150, 120, 0, '{y: 8'd155, u: 8'd107, v: 8'd152, skin: 1'b0, last: 1'b0});
        drain();
        v_min = 8'd152; v_max = 8'd152; u_min = 8'd107; u_max = 8'd107;
        send(200, 150, 120, 1, '{y: 8'd155, u: 8'd107, v: 8'd152, skin: 1'b1, last: 1'b1});
        drain();
        u_min = 8'd108;
        send(200, 150, 120, 0, '{y: 8'd155, u: 8'd107, v: 8'd152, skin: 1'b0, last: 1'b0});
        drain();
        u_min = 8'd73; u_max = 8'd122; v_min = 8'd132; v_max = 8'd173;

        // Streaming under periodic backpressure.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 20; i++)
                    send_m($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'b0);
            end
            begin
                for (int k = 0; k < 90; k++) begin
                    @(posedge clk); #1;
                    out_ready = (k % 3 == 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", n_out - base, 20);

        // Reset with pixels in flight.
        send_m(10, 20, 30, 0);
        send_m(40, 50, 60, 0);
        send_m(70, 80, 90, 0);
        #2 rst_n = 1'b0;
        #1 reset_outputs_zero("midreset");
        sb.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1 chk("no_stale_pixel", out_valid, 1'b0);

`ifdef SKIN_COUNT_EN
        vld_cycles = 0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 1 || i == 3 || i == 6 || i == 8) send_m(200, 150, 120, i == 10);
            else                                      send_m(0, 0, 0, i == 10);
        end
        drain();
        repeat (2) @(posedge clk); #1;
        chk("skin_cnt_frame1", skin_cnt, 4);
        chk("skin_vld_frame1", vld_cycles, 1);
        vld_cycles = 0;
        for (int i = 1; i <= 10; i++) send_m(255, 0, 0, i == 10);
        drain();
        repeat (2) @(posedge clk); #1;
        chk("skin_cnt_frame2", skin_cnt, 0);
        chk("skin_vld_frame2", vld_cycles, 1);
`else
        vld_cycles = 0;
        for (int i = 1; i <= 4; i++) send_m(200, 150, 120, i == 4);
        drain();
        repeat (2) @(posedge clk); #1;
        chk("skin_cnt_tied", skin_cnt, 0);
        chk("skin_vld_tied", vld_cycles, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
